// File: rtl/key_evt_pkg.sv
// key_evt_pkg: shared state encoding and ms-to-cycle conversion for key_event_decoder
package key_evt_pkg;
  typedef enum logic [2:0] {IDLE, PRESS1, WAIT2, PRESS2, LONG_HOLD} state_t;
  function automatic int ms_to_cyc(input int clk_freq, input int ms);
    return clk_freq / 1000 * ms;
  endfunction
endpackage

// File: rtl/key_event_decoder.sv
// key_event_decoder: classifies debounced key gestures into short/long/double-click pulses
//   sys_clk, sys_rst_n (async, active-low)
//   key_flag  : one-cycle strobe, key_value just changed
//   key_value : debounced level, 0 = pressed
//   short_press, long_press, double_click, key_repeat : registered one-cycle pulses
//   key_busy  : FSM not in IDLE
//   Optional auto-repeat while held after a long press: define KEY_REPEAT_EN
module key_event_decoder
  import key_evt_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int LONG_MS   = 1000,
  parameter int DBL_MS    = 300,
  parameter int REPEAT_MS = 200
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic key_flag,
  input  logic key_value,
  output logic short_press,
  output logic long_press,
  output logic double_click,
  output logic key_repeat,
  output logic key_busy
);
  localparam int LONG_CYC = ms_to_cyc(CLK_FREQ, LONG_MS);
  localparam int DBL_CYC  = ms_to_cyc(CLK_FREQ, DBL_MS);
  localparam int REP_CYC  = ms_to_cyc(CLK_FREQ, REPEAT_MS);
  localparam int MAX_LD   = LONG_CYC > DBL_CYC ? LONG_CYC : DBL_CYC;
  localparam int MAX_CYC  = MAX_LD > REP_CYC ? MAX_LD : REP_CYC;
  localparam int CW       = $clog2(MAX_CYC + 1);
  localparam logic [CW-1:0] LONG_T = CW'(LONG_CYC - 1);
  localparam logic [CW-1:0] DBL_T  = CW'(DBL_CYC - 1);
  if (LONG_CYC < 2 || DBL_CYC < 2 || REP_CYC < 2) begin : g_cfg_err
    $error("key_event_decoder: derived cycle counts must be >= 2");
  end
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic press, release_ev, timed, reload;
  logic short_n, long_n, dbl_n, rep_n;
  assign press      = key_flag & ~key_value;
  assign release_ev = key_flag & key_value;
  assign key_busy   = state != IDLE;
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      short_press  <= 1'b0;
      long_press   <= 1'b0;
      double_click <= 1'b0;
      key_repeat   <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      short_press  <= short_n;
      long_press   <= long_n;
      double_click <= dbl_n;
      key_repeat   <= rep_n;
    end
  // Key events are tested before terminal counts, so an edge on the terminal cycle wins.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:      state_n = press ? PRESS1 : IDLE;
      PRESS1:    state_n = release_ev ? WAIT2 : cnt == LONG_T ? LONG_HOLD : PRESS1;
      WAIT2:     state_n = press ? PRESS2 : cnt == DBL_T ? IDLE : WAIT2;
      PRESS2:    state_n = release_ev ? IDLE : cnt == LONG_T ? LONG_HOLD : PRESS2;
      LONG_HOLD: state_n = release_ev ? IDLE : LONG_HOLD;
      default:   state_n = IDLE;
    endcase
  end
`ifdef KEY_REPEAT_EN
  localparam logic [CW-1:0] REP_T = CW'(REP_CYC - 1);
  assign timed  = state != IDLE;
  assign reload = state == LONG_HOLD && cnt == REP_T;
  assign rep_n  = state == LONG_HOLD && !release_ev && cnt == REP_T;
`else
  assign timed  = state == PRESS1 || state == WAIT2 || state == PRESS2;
  assign reload = 1'b0;
  assign rep_n  = 1'b0;
`endif
  always_comb begin
    cnt_n   = (state_n != state || reload) ? '0 : timed ? cnt + CW'(1) : cnt;
    short_n = state == WAIT2 && !press && cnt == DBL_T;
    long_n  = (state == PRESS1 || state == PRESS2) && !release_ev && cnt == LONG_T;
    dbl_n   = state == PRESS2 && release_ev;
  end
endmodule

// File: tb/tb_key_event_decoder.sv
// tb_key_event_decoder: table-driven gestures with a pulse scoreboard for key_event_decoder
module tb_key_event_decoder;
  localparam int L = 20;
  localparam int D = 10;
  localparam int R = 5;
  localparam logic [3:0] M_SHORT = 4'b0001;
  localparam logic [3:0] M_LONG  = 4'b0010;
  localparam logic [3:0] M_DBL   = 4'b0100;
  localparam logic [3:0] M_REP   = 4'b1000;
  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  logic key_flag = 1'b0;
  logic key_value = 1'b1;
  logic short_press, long_press, double_click, key_repeat, key_busy;
  typedef struct {logic [3:0] mask; int at;} exp_t;
  typedef struct {int hold; int gap; int hold2;} vec_t;
  exp_t sbq[$];
  vec_t vecs[12];
  int checks = 0;
  int errors = 0;
  int ec = 0;
  always #5 sys_clk = ~sys_clk;
  key_event_decoder #(.CLK_FREQ(1000), .LONG_MS(L), .DBL_MS(D), .REPEAT_MS(R)) dut (
    .sys_clk(sys_clk),
    .sys_rst_n(sys_rst_n),
    .key_flag(key_flag),
    .key_value(key_value),
    .short_press(short_press),
    .long_press(long_press),
    .double_click(double_click),
    .key_repeat(key_repeat),
    .key_busy(key_busy)
  );
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, ec);
    end
  endtask
  task automatic push(input logic [3:0] m, input int at);
    exp_t e;
    e.mask = m;
    e.at = at;
    sbq.push_back(e);
  endtask
`ifdef KEY_REPEAT_EN
  task automatic push_reps(input int p, input int hold);
    for (int t = p + L + R; t < p + hold; t += R) push(M_REP, t);
  endtask
`endif
  // One clock edge; outputs are sampled 1 time unit later and any pulse is matched to the scoreboard.
  task automatic tick();
    logic [3:0] p;
    exp_t e;
    @(posedge sys_clk);
    #1;
    ec++;
    p = {key_repeat, double_click, long_press, short_press};
    if (sys_rst_n && p != 4'b0) begin
      if ($countones(p) != 1) chk("single_pulse", $countones(p), 1);
      else if (sbq.size() == 0) chk("unexpected_pulse", int'(p), 0);
      else begin
        e = sbq.pop_front();
        chk("pulse_kind", int'(p), int'(e.mask));
        chk("pulse_edge", ec, e.at);
      end
    end
  endtask
  task automatic drive(input logic v);
    key_flag = 1'b1;
    key_value = v;
    tick();
    key_flag = 1'b0;
  endtask
  task automatic idle(input int n);
    repeat (n) tick();
  endtask
  task automatic run_vec(input vec_t v);
    int p;
    int r;
    p = ec + 1;
    if (v.hold > L) begin
      push(M_LONG, p + L);
`ifdef KEY_REPEAT_EN
      push_reps(p, v.hold);
`endif
    end
    drive(1'b0);
    chk("busy_pressed", int'(key_busy), 1);
    idle(v.hold - 1);
    chk("busy_held", int'(key_busy), 1);
    r = ec + 1;
    if (v.hold > L || v.gap == 0) begin
      if (v.hold <= L) push(M_SHORT, r + D);
      drive(1'b1);
    end else begin
      drive(1'b1);
      idle(v.gap - 1);
      p = ec + 1;
      if (v.hold2 > L) begin
        push(M_LONG, p + L);
`ifdef KEY_REPEAT_EN
        push_reps(p, v.hold2);
`endif
      end
      drive(1'b0);
      idle(v.hold2 - 1);
      if (v.hold2 <= L) push(M_DBL, ec + 1);
      drive(1'b1);
    end
    idle(L + 5);
    chk("queue_drained", sbq.size(), 0);
    chk("busy_idle", int'(key_busy), 0);
  endtask
  initial begin
    vecs[0]  = '{5, 0, 0};
    vecs[1]  = '{4, 3, 4};
    vecs[2]  = '{30, 0, 0};
    vecs[3]  = '{20, 0, 0};
    vecs[4]  = '{19, 0, 0};
    vecs[5]  = '{21, 0, 0};
    vecs[6]  = '{4, 10, 4};
    vecs[7]  = '{4, 2, 25};
    vecs[8]  = '{1, 1, 1};
    vecs[9]  = '{37, 0, 0};
    vecs[10] = '{35, 0, 0};
    vecs[11] = '{2, 5, 20};
    #3;
    chk("reset_outputs", int'({key_busy, key_repeat, double_click, long_press, short_press}), 0);
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    tick();
    drive(1'b1);
    chk("post_reset_release_ignored", int'(key_busy), 0);
    foreach (vecs[i]) run_vec(vecs[i]);
    drive(1'b0);
    idle(2);
    drive(1'b0);
    idle(1);
    push(M_SHORT, ec + 1 + D);
    drive(1'b1);
    idle(L + 5);
    chk("dup_press_queue", sbq.size(), 0);
    drive(1'b0);
    idle(3);
    drive(1'b1);
    idle(3);
    chk("busy_wait2", int'(key_busy), 1);
    #2;
    sys_rst_n = 1'b0;
    #1;
    chk("mid_reset_outputs", int'({key_busy, key_repeat, double_click, long_press, short_press}), 0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    tick();
    drive(1'b1);
    idle(D + 5);
    chk("reset_discard_queue", sbq.size(), 0);
    chk("reset_discard_busy", int'(key_busy), 0);
    drive(1'b0);
    idle(4);
    push(M_SHORT, ec + 1 + D);
    drive(1'b1);
    idle(D + 5);
    chk("after_reset_short", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
